// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package mem_arb_pkg;

  // Sequencer states: wait for a request, drive memory, return ack
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester identifiers
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Word alignment: byte-address bits [1:0] are always driven as zero
  localparam logic [63:0] ADDR_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection (combinational).
// Build option: MEM_ARB_FIXED_PRIO_EN makes requester A win every tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid_c,
  output logic grant_id_c
);

  // Pick a winner; on a tie favour the requester not granted last time
  always_comb begin
    grant_valid_c = req_a | req_b;
    grant_id_c    = REQ_A;
    if (req_a && req_b) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_id_c = REQ_A;
`else
      grant_id_c = ~last_grant;
`endif
    end else if (req_b) begin
      grant_id_c = REQ_B;
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority ignores grant history
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer between the CPU data port (A), the display/DMA reader (B)
// and the single-port 256x32 data memory. Every transaction takes
// IDLE -> ACCESS -> RESP, one cycle each, and ends with a one-cycle ack.
// Build option: MEM_ARB_FIXED_PRIO_EN (A always wins simultaneous requests).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqA,
  input  logic                  weA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] wdataA,
  output logic                  ackA,
  output logic [DATA_WIDTH-1:0] rdataA,
  input  logic                  reqB,
  input  logic                  weB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] wdataB,
  output logic                  ackB,
  output logic [DATA_WIDTH-1:0] rdataB,
  output logic                  memoryWrite,
  output logic                  memoryRead,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  input  logic [DATA_WIDTH-1:0] memoryOutData
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(ADDR_ALIGN_MASK);

  state_t                state, state_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  gnt_id, gnt_id_nxt;
  logic                  ack_a_nxt, ack_b_nxt;
  logic [DATA_WIDTH-1:0] rdata_a_nxt, rdata_b_nxt;
  logic                  mem_wr_nxt, mem_rd_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic                  grant_valid_c, grant_id_c;

  rr_arb2 u_rr_arb2 (
    .req_a         (reqA),
    .req_b         (reqB),
    .last_grant    (last_grant),
    .grant_valid_c (grant_valid_c),
    .grant_id_c    (grant_id_c)
  );

  // State and output registers; the memory address/data registers double as
  // the latched transaction, so they simply hold outside a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= REQ_B;
      gnt_id          <= REQ_A;
      ackA            <= 1'b0;
      ackB            <= 1'b0;
      rdataA          <= '0;
      rdataB          <= '0;
      memoryWrite     <= 1'b0;
      memoryRead      <= 1'b0;
      memoryAddress   <= '0;
      memoryWriteData <= '0;
    end else begin
      state           <= state_nxt;
      last_grant      <= last_grant_nxt;
      gnt_id          <= gnt_id_nxt;
      ackA            <= ack_a_nxt;
      ackB            <= ack_b_nxt;
      rdataA          <= rdata_a_nxt;
      rdataB          <= rdata_b_nxt;
      memoryWrite     <= mem_wr_nxt;
      memoryRead      <= mem_rd_nxt;
      memoryAddress   <= mem_addr_nxt;
      memoryWriteData <= mem_wdata_nxt;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt_id_nxt     = gnt_id;
    ack_a_nxt      = 1'b0;
    ack_b_nxt      = 1'b0;
    rdata_a_nxt    = rdataA;
    rdata_b_nxt    = rdataB;
    mem_wr_nxt     = 1'b0;
    mem_rd_nxt     = 1'b0;
    mem_addr_nxt   = memoryAddress;
    mem_wdata_nxt  = memoryWriteData;

    case (state)
      IDLE: begin
        if (grant_valid_c) begin
          state_nxt      = ACCESS;
          gnt_id_nxt     = grant_id_c;
          last_grant_nxt = grant_id_c;
          if (grant_id_c == REQ_A) begin
            mem_wr_nxt    = weA;
            mem_rd_nxt    = ~weA;
            mem_addr_nxt  = addrA & ALIGN_MASK;
            mem_wdata_nxt = wdataA;
          end else begin
            mem_wr_nxt    = weB;
            mem_rd_nxt    = ~weB;
            mem_addr_nxt  = addrB & ALIGN_MASK;
            mem_wdata_nxt = wdataB;
          end
        end
      end

      // Memory is driven this cycle; capture read data and raise the ack
      // so both are visible during RESP
      ACCESS: begin
        state_nxt = RESP;
        if (gnt_id == REQ_A) begin
          ack_a_nxt = 1'b1;
          if (memoryRead) rdata_a_nxt = memoryOutData;
        end else begin
          ack_b_nxt = 1'b1;
          if (memoryRead) rdata_b_nxt = memoryOutData;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 256x32
// memory. Expectations follow MEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqA, weA, ackA;
  logic [31:0] addrA, wdataA, rdataA;
  logic        reqB, weB, ackB;
  logic [31:0] addrB, wdataB, rdataB;
  logic        memoryWrite, memoryRead;
  logic [31:0] memoryAddress, memoryWriteData, memoryOutData;

  int checks = 0;
  int errors = 0;

  // Behavioural memory: unwritten words read back as C0FFEE:<word index>
  logic [31:0]  mem [256];
  logic [255:0] written = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memoryWrite) begin
      mem[memoryAddress[9:2]]     <= memoryWriteData;
      written[memoryAddress[9:2]] <= 1'b1;
    end
  end

  assign memoryOutData = written[memoryAddress[9:2]] ? mem[memoryAddress[9:2]]
                                                     : {24'hC0FFEE, memoryAddress[9:2]};

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .reqA            (reqA),
    .weA             (weA),
    .addrA           (addrA),
    .wdataA          (wdataA),
    .ackA            (ackA),
    .rdataA          (rdataA),
    .reqB            (reqB),
    .weB             (weB),
    .addrB           (addrB),
    .wdataB          (wdataB),
    .ackB            (ackB),
    .rdataB          (rdataB),
    .memoryWrite     (memoryWrite),
    .memoryRead      (memoryRead),
    .memoryAddress   (memoryAddress),
    .memoryWriteData (memoryWriteData),
    .memoryOutData   (memoryOutData)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {24'hC0FFEE, a[9:2]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] cur_a, cur_b;
  logic        who_b;

  initial begin
    rst = 1'b1;
    reqA = 1'b0; weA = 1'b0; addrA = '0; wdataA = '0;
    reqB = 1'b0; weB = 1'b0; addrB = '0; wdataB = '0;
    step();
    step();

    // Reset values
    check("rst_ackA",  32'(ackA), 32'd0);
    check("rst_ackB",  32'(ackB), 32'd0);
    check("rst_wr",    32'(memoryWrite), 32'd0);
    check("rst_rd",    32'(memoryRead), 32'd0);
    check("rst_addr",  memoryAddress, 32'd0);
    check("rst_wdata", memoryWriteData, 32'd0);
    check("rst_rdataA", rdataA, 32'd0);
    check("rst_rdataB", rdataB, 32'd0);

    // A write to 0x10
    rst = 1'b0;
    reqA = 1'b1; weA = 1'b1; addrA = 32'h10; wdataA = 32'hDEADBEEF;
    check("wr_idle_wr", 32'(memoryWrite), 32'd0);
    step();
    check("wr_acc_wr",    32'(memoryWrite), 32'd1);
    check("wr_acc_rd",    32'(memoryRead), 32'd0);
    check("wr_acc_addr",  memoryAddress, 32'h10);
    check("wr_acc_wdata", memoryWriteData, 32'hDEADBEEF);
    check("wr_acc_ackA",  32'(ackA), 32'd0);
    step();
    check("wr_resp_ackA", 32'(ackA), 32'd1);
    check("wr_resp_wr",   32'(memoryWrite), 32'd0);
    check("wr_resp_rd",   32'(memoryRead), 32'd0);
    reqA = 1'b0;
    step();
    check("wr_idle2_ackA", 32'(ackA), 32'd0);

    // A read back from unaligned 0x13
    reqA = 1'b1; weA = 1'b0; addrA = 32'h13;
    step();
    check("rd_acc_addr", memoryAddress, 32'h10);
    check("rd_acc_rd",   32'(memoryRead), 32'd1);
    check("rd_acc_wr",   32'(memoryWrite), 32'd0);
    step();
    check("rd_resp_ackA",  32'(ackA), 32'd1);
    check("rd_resp_rdata", rdataA, 32'hDEADBEEF);
    check("rd_resp_ackB",  32'(ackB), 32'd0);
    check("rd_resp_rd",    32'(memoryRead), 32'd0);
    reqA = 1'b0;
    step();

    // Both requesters reading continuously from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur_a = 32'h40; cur_b = 32'h80;
    reqA = 1'b1; weA = 1'b0; addrA = cur_a;
    reqB = 1'b1; weB = 1'b0; addrB = cur_b;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      who_b = 1'b0;
`else
      who_b = (k % 2) == 1;
`endif
      check($sformatf("both%0d_idle_ackA", k), 32'(ackA), 32'd0);
      check($sformatf("both%0d_idle_ackB", k), 32'(ackB), 32'd0);
      step();
      check($sformatf("both%0d_acc_addr", k), memoryAddress, who_b ? cur_b : cur_a);
      check($sformatf("both%0d_acc_rd", k), 32'(memoryRead), 32'd1);
      step();
      check($sformatf("both%0d_ackA", k), 32'(ackA), 32'(!who_b));
      check($sformatf("both%0d_ackB", k), 32'(ackB), 32'(who_b));
      if (who_b) begin
        check($sformatf("both%0d_rdataB", k), rdataB, pat(cur_b));
        cur_b = cur_b + 32'd4;
        addrB = cur_b;
      end else begin
        check($sformatf("both%0d_rdataA", k), rdataA, pat(cur_a));
        cur_a = cur_a + 32'd4;
        addrA = cur_a;
      end
      step();
    end

    // A drops out: B must be served next
    reqA = 1'b0;
    check("drop_idle_ackB", 32'(ackB), 32'd0);
    step();
    check("drop_acc_addr", memoryAddress, cur_b);
    step();
    check("drop_ackB",   32'(ackB), 32'd1);
    check("drop_rdataB", rdataB, pat(cur_b));
    reqB = 1'b0;
    step();

    // Reset during the ACCESS cycle of a B read
    reqB = 1'b1; weB = 1'b0; addrB = 32'h20;
    step();
    check("rstacc_rd",   32'(memoryRead), 32'd1);
    check("rstacc_addr", memoryAddress, 32'h20);
    rst = 1'b1;
    step();
    check("rstacc_ackB",   32'(ackB), 32'd0);
    check("rstacc_ackA",   32'(ackA), 32'd0);
    check("rstacc_rd0",    32'(memoryRead), 32'd0);
    check("rstacc_wr0",    32'(memoryWrite), 32'd0);
    check("rstacc_addr0",  memoryAddress, 32'd0);
    check("rstacc_wdata0", memoryWriteData, 32'd0);
    check("rstacc_rdataA", rdataA, 32'd0);
    check("rstacc_rdataB", rdataB, 32'd0);
    rst = 1'b0;
    addrB = 32'h24;
    step();
    check("after_rst_acc_addr", memoryAddress, 32'h24);
    check("after_rst_ackB",     32'(ackB), 32'd0);
    step();
    check("after_rst_resp_ackB", 32'(ackB), 32'd1);
    check("after_rst_rdataB",    rdataB, 32'hC0FFEE09);
    reqB = 1'b0;
    step();

    // One-cycle reqB pulse (write) still completes exactly once
    reqB = 1'b1; weB = 1'b1; addrB = 32'h30; wdataB = 32'h12345678;
    step();
    reqB = 1'b0;
    check("pulse_acc_wr",    32'(memoryWrite), 32'd1);
    check("pulse_acc_addr",  memoryAddress, 32'h30);
    check("pulse_acc_wdata", memoryWriteData, 32'h12345678);
    step();
    check("pulse_resp_ackB",  32'(ackB), 32'd1);
    check("pulse_rdataB_kept", rdataB, 32'hC0FFEE09);
    step();
    check("pulse_idle_ackB", 32'(ackB), 32'd0);
    step();
    check("pulse_noacc_wr",   32'(memoryWrite), 32'd0);
    check("pulse_noacc_rd",   32'(memoryRead), 32'd0);
    check("pulse_noacc_ackB", 32'(ackB), 32'd0);
    step();
    check("pulse_noack2_ackB", 32'(ackB), 32'd0);

    // The pulsed write landed in memory
    reqA = 1'b1; weA = 1'b0; addrA = 32'h30;
    step();
    step();
    check("rb30_ackA",  32'(ackA), 32'd1);
    check("rb30_rdataA", rdataA, 32'h12345678);
    reqA = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
